// File: rtl/conv_loop_ctrl_l1.sv
// Layer-1 convolution loop controller: walks the L/J/K window indices, strobes k_zero/temp_zero
// to the adder-tree drain counter and waits for R_zero. Optional stall: CONV_LOOP_CTRL_L1_STALL_EN.
module conv_loop_ctrl_l1 #(
  parameter int unsigned KMAX  = 2,
  parameter int unsigned JMAX  = 2,
  parameter int unsigned LMAX  = 1,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             R_zero,
  output logic [IDX_W-1:0] k_idx,
  output logic [IDX_W-1:0] j_idx,
  output logic [IDX_W-1:0] l_idx,
  output logic             k_zero,
  output logic             temp_zero,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] k_q;
  logic [IDX_W-1:0] j_q;
  logic [IDX_W-1:0] l_q;
  logic             first_q;
  logic             advance_c;
  logic             k_wrap_c;
  logic             j_wrap_c;
  logic             l_wrap_c;
  logic             last_beat_c;

  // A beat is consumed every RUN cycle unless the datapath holds the loop.
`ifdef CONV_LOOP_CTRL_L1_STALL_EN
  assign advance_c = (state_q == S_RUN) && !stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign advance_c    = (state_q == S_RUN);
`endif

  assign k_wrap_c    = (k_q == IDX_W'(KMAX));
  assign j_wrap_c    = (j_q == IDX_W'(JMAX));
  assign l_wrap_c    = (l_q == IDX_W'(LMAX));
  assign last_beat_c = advance_c && k_wrap_c && j_wrap_c && l_wrap_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; R_zero only counts once the last beat has left RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)       state_d = S_RUN;
      S_RUN:   if (last_beat_c) state_d = S_DRAIN;
      S_DRAIN: if (R_zero)      state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Nested K (inner) / J / L (outer) index counters, cleared outside RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q <= '0;
      j_q <= '0;
      l_q <= '0;
    end else if (state_q != S_RUN) begin
      k_q <= '0;
      j_q <= '0;
      l_q <= '0;
    end else if (advance_c) begin
      if (k_wrap_c) begin
        k_q <= '0;
        if (j_wrap_c) begin
          j_q <= '0;
          l_q <= l_wrap_c ? '0 : l_q + IDX_W'(1);
        end else begin
          j_q <= j_q + IDX_W'(1);
        end
      end else begin
        k_q <= k_q + IDX_W'(1);
      end
    end
  end

  // Marks the first beat of a pass until that beat is actually consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      first_q <= 1'b1;
    end else if (advance_c) begin
      first_q <= 1'b0;
    end
  end

  // Output decode from registered state
  always_comb begin
    k_idx     = k_q;
    j_idx     = j_q;
    l_idx     = l_q;
    k_zero    = 1'b0;
    temp_zero = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RUN: begin
        valid     = 1'b1;
        busy      = 1'b1;
        k_zero    = advance_c && k_wrap_c;
        temp_zero = advance_c && first_q;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_loop_ctrl_l1.sv
// Scoreboard bench for conv_loop_ctrl_l1: stimulus queues expected beats/done pulses, a negedge
// monitor pops and compares whenever the controller presents them.
module tb_conv_loop_ctrl_l1;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned NBEAT = 18;
`ifdef CONV_LOOP_CTRL_L1_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             R_zero = 1'b0;
  logic [IDX_W-1:0] k_idx;
  logic [IDX_W-1:0] j_idx;
  logic [IDX_W-1:0] l_idx;
  logic             k_zero;
  logic             temp_zero;
  logic             valid;
  logic             busy;
  logic             done;

  conv_loop_ctrl_l1 #(.KMAX(2), .JMAX(2), .LMAX(1), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .R_zero    (R_zero),
    .k_idx     (k_idx),
    .j_idx     (j_idx),
    .l_idx     (l_idx),
    .k_zero    (k_zero),
    .temp_zero (temp_zero),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Period p is the clock period following rising edge number p.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  k;
    logic [3:0]  j;
    logic [3:0]  l;
    logic        kz;
    logic        tz;
  } beat_t;

  beat_t       beat_q[$];
  int unsigned done_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  beat_t       mon_act;
  beat_t       mon_exp;
  int unsigned mon_done;

  // Monitor: compares every presented beat and done pulse against the queues
  always @(negedge clk) begin
    if (rst) begin
      if (valid && !(STALL_EN && stall)) begin
        mon_act.cyc = cyc;
        mon_act.k   = k_idx;
        mon_act.j   = j_idx;
        mon_act.l   = l_idx;
        mon_act.kz  = k_zero;
        mon_act.tz  = temp_zero;
        n_vec++;
        if (beat_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat cyc=%0d k=%0d j=%0d l=%0d kz=%0b tz=%0b, expected none",
                   mon_act.cyc, mon_act.k, mon_act.j, mon_act.l, mon_act.kz, mon_act.tz);
        end else begin
          mon_exp = beat_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL beat: got cyc=%0d k=%0d j=%0d l=%0d kz=%0b tz=%0b, expected cyc=%0d k=%0d j=%0d l=%0d kz=%0b tz=%0b",
                     mon_act.cyc, mon_act.k, mon_act.j, mon_act.l, mon_act.kz, mon_act.tz,
                     mon_exp.cyc, mon_exp.k, mon_exp.j, mon_exp.l, mon_exp.kz, mon_exp.tz);
          end
        end
      end else if (valid) begin
        n_vec++;
        if ({k_zero, temp_zero} !== 2'b00) begin
          n_err++;
          $display("FAIL stall_strobe: cyc=%0d kz=%0b tz=%0b, expected 0 0", cyc, k_zero, temp_zero);
        end
      end else begin
        n_vec++;
        if ({k_idx, j_idx, l_idx, k_zero, temp_zero} !== '0) begin
          n_err++;
          $display("FAIL idle_out: cyc=%0d k=%0d j=%0d l=%0d kz=%0b tz=%0b, expected all 0",
                   cyc, k_idx, j_idx, l_idx, k_zero, temp_zero);
        end
      end
      if (done) begin
        n_vec++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL done: unexpected done at cyc=%0d, expected none", cyc);
        end else begin
          mon_done = done_q.pop_front();
          if ((cyc != mon_done) || (busy !== 1'b1)) begin
            n_err++;
            $display("FAIL done: got cyc=%0d busy=%0b, expected cyc=%0d busy=1", cyc, busy, mon_done);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned p);
    while (cyc < p) tick();
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if ({k_idx, j_idx, l_idx, k_zero, temp_zero, valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL %s: cyc=%0d k=%0d j=%0d l=%0d kz=%0b tz=%0b valid=%0b busy=%0b done=%0b, expected all 0",
               name, cyc, k_idx, j_idx, l_idx, k_zero, temp_zero, valid, busy, done);
    end
  endtask

  // Expected beats of one pass starting in period s; beats after the first shift by 'shift'
  task automatic push_pass(input int unsigned s, input int unsigned shift, input int unsigned n);
    beat_t b;
    for (int i = 0; i < int'(n); i++) begin
      b.cyc = 32'(s + 32'(i) + ((i >= 1) ? shift : 0));
      b.k   = 4'(i % 3);
      b.j   = 4'((i / 3) % 3);
      b.l   = 4'(i / 9);
      b.kz  = ((i % 3) == 2);
      b.tz  = (i == 0);
      beat_q.push_back(b);
    end
  endtask

  task automatic pulse_start(output int unsigned s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic rzero_at(input int unsigned p);
    wait_until(p);
    R_zero = 1'b1;
    tick();
    R_zero = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned s;
    int unsigned s2;
    int unsigned shift;
    int unsigned last;

    // Reset then idle
    tick();
    check_all_zero("reset");
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all_zero("idle");
    end

    // Plain pass: R_zero four periods after the last k_zero
    pulse_start(s);
    push_pass(s, 0, NBEAT);
    done_q.push_back(s + 22);
    rzero_at(s + 21);
    wait_until(s + 24);
    check_all_zero("after_pass");

    // Stall over spec cycles 2-4
    shift = STALL_EN ? 3 : 0;
    pulse_start(s);
    push_pass(s, shift, NBEAT);
    last = s + 17 + shift;
    done_q.push_back(last + 5);
    tick();
    stall = 1'b1;
    wait_until(s + 4);
    stall = 1'b0;
    rzero_at(last + 4);
    wait_until(last + 7);
    check_all_zero("after_stall");

    // R_zero high through RUN and the last beat must not end the pass early
    pulse_start(s);
    push_pass(s, 0, NBEAT);
    done_q.push_back(s + 21);
    wait_until(s + 5);
    R_zero = 1'b1;
    wait_until(s + 18);
    R_zero = 1'b0;
    rzero_at(s + 20);
    wait_until(s + 23);
    check_all_zero("after_early_rzero");

    // start pulses in RUN and DRAIN are ignored
    pulse_start(s);
    push_pass(s, 0, NBEAT);
    done_q.push_back(s + 22);
    wait_until(s + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(s + 19);
    start = 1'b1;
    tick();
    start = 1'b0;
    rzero_at(s + 21);
    wait_until(s + 24);
    check_all_zero("after_start_ignored");

    // start held: back-to-back passes with one IDLE period between
    start = 1'b1;
    tick();
    s = cyc;
    push_pass(s, 0, NBEAT);
    done_q.push_back(s + 22);
    rzero_at(s + 21);
    s2 = s + 24;
    push_pass(s2, 0, NBEAT);
    done_q.push_back(s2 + 22);
    wait_until(s + 23);
    check_all_zero("idle_gap");
    rzero_at(s2 + 21);
    start = 1'b0;
    wait_until(s2 + 24);
    check_all_zero("after_held");

    // Reset at beat 10: outputs clear at once, no done, then a full pass
    pulse_start(s);
    push_pass(s, 0, 9);
    wait_until(s + 9);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    check_all_zero("rst_mid_hold");
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("after_rst");
    pulse_start(s);
    push_pass(s, 0, NBEAT);
    done_q.push_back(s + 22);
    rzero_at(s + 21);
    wait_until(s + 24);
    check_all_zero("final_idle");

    n_vec++;
    if ((beat_q.size() != 0) || (done_q.size() != 0)) begin
      n_err++;
      $display("FAIL drain_queues: beats left=%0d dones left=%0d, expected 0 0", beat_q.size(), done_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_loop_ctrl_l1.md
# conv_loop_ctrl_l1

Layer-1 convolution loop controller. It drives the nested L/J/K window-index loops that feed the layer-1 MAC array and adder tree. It issues the `k_zero` and `temp_zero` strobes consumed by the layer-1 adder-tree drain counter, then waits for that counter's `R_zero` before reporting the pass complete. It is the initiator side of the k_zero/temp_zero → R_zero exchange and sits between the layer sequencer (start/done) and the datapath.

## Interface
- `KMAX`, default 2: last K index (innermost loop, 0..KMAX).
- `JMAX`, default 2: last J index (middle loop, 0..JMAX).
- `LMAX`, default 1: last L index (outer loop, 0..LMAX).
- `IDX_W`, default 4: width of each index output; must hold max(KMAX, JMAX, LMAX).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin one pass; sampled in IDLE only.
- `stall`, input, 1: datapath not ready; freezes the loop (see Configuration).
- `R_zero`, input, 1: adder-tree drain complete, from the drain counter.
- `k_idx`, `j_idx`, `l_idx`, output, IDX_W each: current loop indices.
- `k_zero`, output, 1: K loop wraps this cycle.
- `temp_zero`, output, 1: first-beat strobe of the pass.
- `valid`, output, 1: indices are valid for the datapath this cycle.
- `busy`, output, 1: high from the first RUN cycle through the DONE cycle.
- `done`, output, 1: one-cycle pass-complete pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Encoding is free.
- IDLE: indices held at 0. `start`=1 → RUN.
- RUN: `valid`=1. On each advance, K increments. When K==KMAX, K→0 and J increments. When J==JMAX as well, J→0 and L increments. The advance happens every cycle unless stalled.
- `k_zero` = RUN & (k_idx==KMAX) & advance. It is combinational from registered state.
- `temp_zero`: 1 only in the first RUN cycle (l=j=k=0, first beat). Stall does not stretch it beyond that cycle.
- Last beat (l=LMAX, j=JMAX, k=KMAX, advance): `k_zero`=1, indices return to 0, next state is DRAIN.
- DRAIN: `valid`=0, indices 0. Wait for `R_zero`=1, then go to DONE. If `R_zero` arrives in the same cycle the last beat is issued, it is ignored; only `R_zero` sampled while in DRAIN counts.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `start` held high through DONE begins a new pass on the first IDLE cycle.
- Beats per pass: (KMAX+1)(JMAX+1)(LMAX+1). `k_zero` pulses per pass: (JMAX+1)(LMAX+1).

## Timing
- Reset values: state IDLE; `k_idx`=`j_idx`=`l_idx`=0; `k_zero`=`temp_zero`=`valid`=`busy`=`done`=0.
- `start` high at edge n → RUN from cycle n+1, with `temp_zero`=`valid`=`busy`=1 and indices 0.
- Unstalled pass: beats occupy cycles n+1 .. n+B, where B is the beat count. DRAIN starts at n+B+1.
- `R_zero` sampled high at edge m (in DRAIN) → `done`=1 in cycle m+1 → IDLE at m+2.
- Stall cycle: indices, `temp_zero` and `k_zero` are frozen or suppressed. `valid` stays 1 while stalled; the datapath qualifies `valid` with `!stall`.
- Reset asserted mid-pass: immediate return to reset values. No `done` is issued.

## Configuration
- `CONV_LOOP_CTRL_L1_STALL_EN` defined: `stall` behaves as above.
- `CONV_LOOP_CTRL_L1_STALL_EN` undefined: `stall` is ignored and the loop advances every RUN cycle. The port remains present and unused.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, indices 0.
- Defaults, `start` pulse at edge 0 (R_zero tied to a drain counter model returning R_zero 4 cycles after the last `k_zero`):
  - 18 beats in cycles 1–18.
  - `k_zero` in cycles 3, 6, …, 18 (6 pulses).
  - `temp_zero` only in cycle 1.
  - `done` one cycle after R_zero is sampled.
- STALL_EN build, `stall`=1 in cycles 2–4: beat indices identical, shifted by 3 cycles; the first `k_zero` moves to cycle 6; `temp_zero` still only in cycle 1.
- `R_zero` forced high during RUN and in the last-beat cycle: no early exit. Controller reaches DRAIN, then completes on the first `R_zero` seen in DRAIN.
- `start` pulsed during RUN and DRAIN: ignored, beat count still 18. `start` held high: back-to-back passes with exactly one IDLE cycle between them.
- `rst` low at beat 10: all outputs 0 in the same cycle. After release, a new `start` gives a full 18-beat pass.
